counter_nb: RTL and testbench

COUNTER_NB -- requirements
Module: counter_nb

---
 rtl/counter_pkg.sv | 11 +
 rtl/counter_nb_tc.sv | 24 ++
 rtl/counter_nb.sv | 60 ++++++
 tb/tb_counter_nb.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: direction constants and terminal-value helper shared by the counter blocks
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic longint unsigned terminal(input logic dir, input longint unsigned modulus);
        return (dir == DIR_UP) ? modulus - 64'd1 : 64'd0;
    endfunction

endpackage

// File: rtl/counter_nb_tc.sv
// counter_nb_tc: combinational terminal-count compare and cascade ripple carry
module counter_nb_tc
    import counter_pkg::*;
#(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MODULUS = 16
) (
    input  logic [WIDTH-1:0] q,
    input  logic             en,
    input  logic             ci,
    input  logic             up,
    input  logic             load,
    input  logic             rst,
    output logic             tc,
    output logic             rc
);

    // terminal value depends on direction; rc is masked while load or reset own the edge
    always_comb begin
        tc = (q == WIDTH'(terminal(up, MODULUS)));
        rc = en & ci & tc & ~load & ~rst;
    end

endmodule

// File: rtl/counter_nb.sv
// counter_nb: cascadable modulo up/down counter with load, ripple carry and wrap pulse
module counter_nb
    import counter_pkg::*;
#(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ci,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             rc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX   = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);

    logic             tc;
    logic             step;
    logic             wrap_nxt;
    logic [WIDTH-1:0] q_nxt;

    counter_nb_tc #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_tc (
        .q    (q),
        .en   (en),
        .ci   (ci),
        .up   (up),
        .load (load),
        .rst  (rst),
        .tc   (tc),
        .rc   (rc)
    );

    // next count: load beats counting; a step at the terminal value wraps to the opposite end
    always_comb begin
        step     = en & ci;
        q_nxt    = load ? (({1'b0, d} < MOD_W) ? d : '0)
                 : step ? (tc ? (up ? '0 : MAX) : (up ? q + ONE : q - ONE))
                 : q;
        wrap_nxt = ~load & step & tc;
    end

    // count and wrap registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            q    <= q_nxt;
            wrap <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_counter_nb.sv
// tb_counter_nb: directed table, cascade, toggle and randomized checks of counter_nb
module tb_counter_nb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    logic       a_en = 0, a_ci = 1, a_up = 1, a_load = 0;
    logic [3:0] a_d = 0, a_q;
    logic       a_rc, a_wrap;

    logic       p_en = 0, p_ci = 1, p_up = 1, p_load = 0;
    logic [3:0] p_d = 0, p_q;
    logic       p_rc, p_wrap;

    logic       t_en = 0, t_ci = 1, t_up = 1, t_load = 0;
    logic [0:0] t_d = 0, t_q;
    logic       t_rc, t_wrap;

    logic       c_en = 0;
    logic [3:0] c_q0, c_q1;
    logic       c_rc0, c_rc1, c_w0, c_w1;

    counter_nb #(.WIDTH(4), .MODULUS(10)) dut_a (
        .clk(clk), .rst(rst), .en(a_en), .ci(a_ci), .up(a_up), .load(a_load),
        .d(a_d), .q(a_q), .rc(a_rc), .wrap(a_wrap));

    counter_nb #(.WIDTH(4), .MODULUS(16)) dut_p (
        .clk(clk), .rst(rst), .en(p_en), .ci(p_ci), .up(p_up), .load(p_load),
        .d(p_d), .q(p_q), .rc(p_rc), .wrap(p_wrap));

    counter_nb #(.WIDTH(1), .MODULUS(2)) dut_t (
        .clk(clk), .rst(rst), .en(t_en), .ci(t_ci), .up(t_up), .load(t_load),
        .d(t_d), .q(t_q), .rc(t_rc), .wrap(t_wrap));

    counter_nb #(.WIDTH(4), .MODULUS(10)) dut_c0 (
        .clk(clk), .rst(rst), .en(c_en), .ci(1'b1), .up(1'b1), .load(1'b0),
        .d(4'd0), .q(c_q0), .rc(c_rc0), .wrap(c_w0));

    counter_nb #(.WIDTH(4), .MODULUS(10)) dut_c1 (
        .clk(clk), .rst(rst), .en(c_en), .ci(c_rc0), .up(1'b1), .load(1'b0),
        .d(4'd0), .q(c_q1), .rc(c_rc1), .wrap(c_w1));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference: next value from the modulo rules
    function automatic int nq(int q, int m, bit r, bit ld, int dv, bit stp, bit u);
        if (r) return 0;
        if (ld) return (dv >= m) ? 0 : dv;
        if (stp) return u ? (q + 1) % m : (q + m - 1) % m;
        return q;
    endfunction

    // reference: a counting step sits on the boundary for its direction
    function automatic bit edge_hit(int q, int m, bit r, bit ld, bit stp, bit u);
        return !r && !ld && stp && (u ? (q == m - 1) : (q == 0));
    endfunction

    typedef struct {
        logic       rst, load, en, ci, up;
        logic [3:0] d, q;
        logic       rc, wrap;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int ma, mp, mt;
        bit wa, wp, wt;
        tbl[0]  = '{0, 1, 0, 1, 1, 4'd2,  4'd2, 0, 0};
        tbl[1]  = '{0, 0, 1, 1, 0, 4'd0,  4'd1, 0, 0};
        tbl[2]  = '{0, 0, 1, 1, 0, 4'd0,  4'd0, 0, 0};
        tbl[3]  = '{0, 0, 1, 1, 0, 4'd0,  4'd9, 1, 1};
        tbl[4]  = '{0, 0, 0, 1, 0, 4'd0,  4'd9, 0, 0};
        tbl[5]  = '{0, 0, 1, 1, 1, 4'd0,  4'd0, 1, 1};
        tbl[6]  = '{0, 1, 1, 1, 1, 4'd12, 4'd0, 0, 0};
        tbl[7]  = '{0, 1, 1, 1, 1, 4'd7,  4'd7, 0, 0};
        tbl[8]  = '{0, 0, 1, 0, 1, 4'd0,  4'd7, 0, 0};
        tbl[9]  = '{1, 1, 1, 1, 1, 4'd3,  4'd0, 0, 0};
        tbl[10] = '{0, 0, 1, 1, 1, 4'd0,  4'd1, 0, 0};
        tbl[11] = '{0, 0, 1, 1, 0, 4'd0,  4'd0, 0, 0};
        tbl[12] = '{0, 1, 1, 1, 1, 4'd9,  4'd9, 0, 0};
        tbl[13] = '{0, 0, 1, 1, 0, 4'd0,  4'd8, 0, 0};

        tick();
        chk("reset_q", a_q, 0);
        chk("reset_wrap", a_wrap, 0);
        chk("reset_cq", {c_q1, c_q0}, 0);
        rst = 0;

        c_en = 1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (i == 45) chk("casc_45", {c_q1, c_q0}, {4'd4, 4'd5});
            if (i == 99) chk("casc_99", {c_q1, c_q0}, {4'd9, 4'd9});
            if (i == 100) begin
                chk("casc_100", {c_q1, c_q0}, 0);
                chk("casc_wrap1", c_w1, 1);
            end
        end
        c_en = 0;

        a_en = 1; a_ci = 1; a_up = 1;
        for (int i = 0; i <= 10; i++) begin
            #1;
            chk("up_rc", a_rc, (i % 10) == 9);
            tick();
            chk("up_q", a_q, (i + 1) % 10);
            chk("up_wrap", a_wrap, i == 9);
        end

        for (int i = 0; i < 14; i++) begin
            rst = tbl[i].rst; a_load = tbl[i].load; a_en = tbl[i].en;
            a_ci = tbl[i].ci; a_up = tbl[i].up; a_d = tbl[i].d;
            #1;
            chk($sformatf("tbl%0d_rc", i), a_rc, tbl[i].rc);
            tick();
            chk($sformatf("tbl%0d_q", i), a_q, tbl[i].q);
            chk($sformatf("tbl%0d_wrap", i), a_wrap, tbl[i].wrap);
        end
        rst = 0; a_load = 0; a_en = 0;

        rst = 1;
        tick();
        rst = 0;
        t_en = 1;
        for (int i = 0; i < 8; i++) begin
            t_up = (i % 2 == 0);
            #1;
            chk("tog_rc", t_rc, 0);
            tick();
            chk("tog_q", t_q, t_up ? 1 : 0);
            chk("tog_wrap", t_wrap, 0);
        end

        rst = 1;
        tick();
        ma = 0; mp = 0; mt = 0;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(15) == 0);
            a_load = ($urandom_range(7) == 0); a_en = $urandom; a_ci = ($urandom_range(3) != 0);
            a_up = $urandom; a_d = 4'($urandom_range(15));
            p_load = ($urandom_range(7) == 0); p_en = $urandom; p_ci = ($urandom_range(3) != 0);
            p_up = $urandom; p_d = 4'($urandom_range(15));
            t_load = ($urandom_range(7) == 0); t_en = $urandom; t_ci = $urandom;
            t_up = $urandom; t_d = 1'($urandom_range(1));
            #1;
            wa = edge_hit(ma, 10, rst, a_load, a_en & a_ci, a_up);
            wp = edge_hit(mp, 16, rst, p_load, p_en & p_ci, p_up);
            wt = edge_hit(mt, 2, rst, t_load, t_en & t_ci, t_up);
            chk("rnd_a_rc", a_rc, wa);
            chk("rnd_p_rc", p_rc, wp);
            chk("rnd_t_rc", t_rc, wt);
            ma = nq(ma, 10, rst, a_load, int'(a_d), a_en & a_ci, a_up);
            mp = nq(mp, 16, rst, p_load, int'(p_d), p_en & p_ci, p_up);
            mt = nq(mt, 2, rst, t_load, int'(t_d), t_en & t_ci, t_up);
            tick();
            chk("rnd_a_q", a_q, ma);
            chk("rnd_a_wrap", a_wrap, wa);
            chk("rnd_p_q", p_q, mp);
            chk("rnd_p_wrap", p_wrap, wp);
            chk("rnd_t_q", t_q, mt);
            chk("rnd_t_wrap", t_wrap, wt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
